// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store controller in front of the 512x8 data RAM.
// Checks alignment, registers all RAM controls and splits LDD/STD into two word accesses.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W = 9
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  input  logic              i_req_load,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_signed,
  input  logic [31:0]       i_req_addr,
  input  logic [31:0]       i_req_wdata,
  input  logic [31:0]       i_req_wdata_hi,
  output logic              o_stall,
  output logic              o_trap_align,
  output logic [31:0]       o_rdata,
  output logic [31:0]       o_rdata_hi,
  output logic              o_rdata_valid,
  output logic              o_ram_en,
  output logic              o_ram_rw,
  output logic              o_ram_sign,
  output logic [1:0]        o_ram_size,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [31:0]       o_ram_din,
  input  logic [31:0]       i_ram_dout
);

  typedef enum logic [2:0] {StIdle, StAccLo, StAccHi, StResp, StTrap} state_e;

  state_e              r_state;
  logic                r_trap_align;
  logic [31:0]         r_rdata;
  logic [31:0]         r_rdata_hi;
  logic                r_rdata_valid;
  logic                r_ram_en;
  logic                r_ram_rw;
  logic                r_ram_sign;
  logic [1:0]          r_ram_size;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [31:0]         r_ram_din;
  logic                r_load;
  logic                r_dword;
  logic                w_misaligned;
  logic                w_sub_word;

  always_comb begin
    w_misaligned = 1'b0;
    case (i_req_size)
      2'b01:   w_misaligned = i_req_addr[0];
      2'b10:   w_misaligned = |i_req_addr[1:0];
      2'b11:   w_misaligned = |i_req_addr[2:0];
      default: w_misaligned = 1'b0;
    endcase
  end

  assign w_sub_word = ~i_req_size[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StIdle;
      r_trap_align  <= 1'b0;
      r_rdata       <= '0;
      r_rdata_hi    <= '0;
      r_rdata_valid <= 1'b0;
      r_ram_en      <= 1'b0;
      r_ram_rw      <= 1'b0;
      r_ram_sign    <= 1'b0;
      r_ram_size    <= '0;
      r_ram_addr    <= '0;
      r_ram_din     <= '0;
      r_load        <= 1'b0;
      r_dword       <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_req_valid) begin
            if (w_misaligned) begin
              r_state      <= StTrap;
              r_trap_align <= 1'b1;
            end else begin
              r_state    <= StAccLo;
              r_load     <= i_req_load;
              r_dword    <= &i_req_size;
              r_ram_en   <= 1'b1;
              r_ram_rw   <= ~i_req_load;
              r_ram_size <= (&i_req_size) ? 2'b10 : i_req_size;
              r_ram_sign <= i_req_load & i_req_signed & w_sub_word;
              r_ram_addr <= i_req_addr[ADDR_W-1:0];
              r_ram_din  <= i_req_wdata;
            end
          end
        end
        StAccLo: begin
          if (r_load) r_rdata <= i_ram_dout;
          if (r_dword) begin
            // Even register sits at the lower address; odd register follows 4 bytes up.
            r_state    <= StAccHi;
            r_ram_addr <= r_ram_addr + ADDR_W'(4);
            r_ram_din  <= i_req_wdata_hi;
            r_ram_size <= 2'b10;
            r_ram_sign <= 1'b0;
          end else begin
            r_state       <= StResp;
            r_ram_en      <= 1'b0;
            r_ram_rw      <= 1'b0;
            r_rdata_valid <= r_load;
          end
        end
        StAccHi: begin
          if (r_load) r_rdata_hi <= i_ram_dout;
          r_state       <= StResp;
          r_ram_en      <= 1'b0;
          r_ram_rw      <= 1'b0;
          r_rdata_valid <= r_load;
        end
        StResp: begin
          r_state       <= StIdle;
          r_rdata_valid <= 1'b0;
        end
        StTrap: begin
          r_state      <= StIdle;
          r_trap_align <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_stall       = ((r_state == StIdle) & i_req_valid) | (r_state == StAccLo) |
                         (r_state == StAccHi);
  assign o_trap_align  = r_trap_align;
  assign o_rdata       = r_rdata;
  assign o_rdata_hi    = r_rdata_hi;
  assign o_rdata_valid = r_rdata_valid;
  assign o_ram_en      = r_ram_en;
  assign o_ram_rw      = r_ram_rw;
  assign o_ram_sign    = r_ram_sign;
  assign o_ram_size    = r_ram_size;
  assign o_ram_addr    = r_ram_addr;
  assign o_ram_din     = r_ram_din;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl with a big-endian 512x8 RAM model attached.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_load = 1'b0;
  logic [1:0]  req_size = '0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] req_wdata_hi = '0;
  logic        stall, trap_align, rdata_valid;
  logic [31:0] rdata, rdata_hi;
  logic        ram_en, ram_rw, ram_sign;
  logic [1:0]  ram_size;
  logic [8:0]  ram_addr;
  logic [31:0] ram_din, ram_dout;

  logic [7:0]  mem [512];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(9)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_load(req_load),
    .i_req_size(req_size), .i_req_signed(req_signed), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .i_req_wdata_hi(req_wdata_hi), .o_stall(stall),
    .o_trap_align(trap_align), .o_rdata(rdata), .o_rdata_hi(rdata_hi),
    .o_rdata_valid(rdata_valid), .o_ram_en(ram_en), .o_ram_rw(ram_rw), .o_ram_sign(ram_sign),
    .o_ram_size(ram_size), .o_ram_addr(ram_addr), .o_ram_din(ram_din), .i_ram_dout(ram_dout)
  );

  always_comb begin
    ram_dout = '0;
    case (ram_size)
      2'b00:   ram_dout = {{24{ram_sign & mem[ram_addr][7]}}, mem[ram_addr]};
      2'b01:   ram_dout = {{16{ram_sign & mem[ram_addr][7]}}, mem[ram_addr], mem[ram_addr+9'd1]};
      default: ram_dout = {mem[ram_addr], mem[ram_addr+9'd1], mem[ram_addr+9'd2],
                           mem[ram_addr+9'd3]};
    endcase
  end

  always @(posedge clk) begin
    if (ram_en && ram_rw) begin
      case (ram_size)
        2'b00: mem[ram_addr] <= ram_din[7:0];
        2'b01: begin
          mem[ram_addr]      <= ram_din[15:8];
          mem[ram_addr+9'd1] <= ram_din[7:0];
        end
        default: begin
          mem[ram_addr]      <= ram_din[31:24];
          mem[ram_addr+9'd1] <= ram_din[23:16];
          mem[ram_addr+9'd2] <= ram_din[15:8];
          mem[ram_addr+9'd3] <= ram_din[7:0];
        end
      endcase
    end
  end

  typedef struct {
    string       name;
    logic        load;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] wdh;
    int          e_stall;
    int          e_trap;
    int          e_valid;
    int          e_en;
    int          e_wr;
    logic [8:0]  e_a0;
    logic [8:0]  e_a1;
    logic [1:0]  e_sz0;
    logic        e_sign;
    logic        chk_rd;
    logic [31:0] e_rdata;
    logic        chk_hi;
    logic [31:0] e_rdata_hi;
  } vec_t;

  vec_t vecs[$];

  int         n_stall, n_trap, n_valid, n_en, n_wr, n_stray;
  logic [8:0] g_a0, g_a1;
  logic [1:0] g_sz0;
  logic       g_sign;

  function automatic logic [31:0] mem_word(input logic [8:0] a);
    return {mem[a], mem[a+9'd1], mem[a+9'd2], mem[a+9'd3]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drives one request starting in an IDLE cycle; returns in the next IDLE cycle.
  task automatic run_op(input vec_t v);
    bit done = 0;
    req_valid = 1'b1; req_load = v.load; req_size = v.size; req_signed = v.sgn;
    req_addr = v.addr; req_wdata = v.wd; req_wdata_hi = v.wdh;
    n_stall = 0; n_trap = 0; n_valid = 0; n_en = 0; n_wr = 0; n_stray = 0;
    g_a0 = '0; g_a1 = '0; g_sz0 = '0; g_sign = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      if (stall) n_stall++;
      if (trap_align) n_trap++;
      if (rdata_valid) n_valid++;
      if (ram_en) begin
        if (n_en == 0) begin
          g_a0 = ram_addr; g_sz0 = ram_size; g_sign = ram_sign;
        end else begin
          g_a1 = ram_addr;
        end
        n_en++;
        if (ram_rw) n_wr++;
      end else if (ram_rw) begin
        n_stray++;
      end
      done = !stall;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL %s timeout: stall still 1 after 10 cycles, expected release", v.name);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
    #1;
    mem[0] <= 8'h01; mem[1] <= 8'h02; mem[2] <= 8'h03; mem[3] <= 8'h91;
    mem[4] <= 8'h12; mem[5] <= 8'h34; mem[6] <= 8'h56; mem[7] <= 8'h78;

    //        name      ld sz     sg addr     wd            wdh           st tr va en wr a0      a1      sz0    sgn chkrd rdata         chkhi rdata_hi
    vecs.push_back('{"ld_w4",   1, 2'b10, 0, 32'h004, 32'h0, 32'h0,       2, 0, 1, 1, 0, 9'h004, 9'h000, 2'b10, 0, 1, 32'h12345678, 0, 32'h0});
    vecs.push_back('{"ld_sb3",  1, 2'b00, 1, 32'h003, 32'h0, 32'h0,       2, 0, 1, 1, 0, 9'h003, 9'h000, 2'b00, 1, 1, 32'hFFFFFF91, 0, 32'h0});
    vecs.push_back('{"ld_ub3",  1, 2'b00, 0, 32'h003, 32'h0, 32'h0,       2, 0, 1, 1, 0, 9'h003, 9'h000, 2'b00, 0, 1, 32'h00000091, 0, 32'h0});
    vecs.push_back('{"std8",    0, 2'b11, 0, 32'h008, 32'hAEEABBA6, 32'h0000BBCC, 3, 0, 0, 2, 2, 9'h008, 9'h00C, 2'b10, 0, 0, 32'h0, 0, 32'h0});
    vecs.push_back('{"ldd8",    1, 2'b11, 1, 32'h008, 32'h0, 32'h0,       3, 0, 1, 2, 0, 9'h008, 9'h00C, 2'b10, 0, 1, 32'hAEEABBA6, 1, 32'h0000BBCC});
    vecs.push_back('{"ld_sh10", 1, 2'b01, 1, 32'h00A, 32'h0, 32'h0,       2, 0, 1, 1, 0, 9'h00A, 9'h000, 2'b01, 1, 1, 32'hFFFFBBA6, 1, 32'h0000BBCC});
    vecs.push_back('{"mis_h5",  1, 2'b01, 0, 32'h005, 32'h0, 32'h0,       1, 1, 0, 0, 0, 9'h000, 9'h000, 2'b00, 0, 1, 32'hFFFFBBA6, 1, 32'h0000BBCC});
    vecs.push_back('{"mis_d4",  1, 2'b11, 0, 32'h004, 32'h0, 32'h0,       1, 1, 0, 0, 0, 9'h000, 9'h000, 2'b00, 0, 1, 32'hFFFFBBA6, 1, 32'h0000BBCC});
    vecs.push_back('{"ld_wrap", 1, 2'b10, 0, 32'h204, 32'h0, 32'h0,       2, 0, 1, 1, 0, 9'h004, 9'h000, 2'b10, 0, 1, 32'h12345678, 1, 32'h0000BBCC});
    vecs.push_back('{"st_b0",   0, 2'b00, 1, 32'h000, 32'hFFFFFFA6, 32'h0, 2, 0, 0, 1, 1, 9'h000, 9'h000, 2'b00, 0, 0, 32'h0, 0, 32'h0});
    vecs.push_back('{"ld_w0",   1, 2'b10, 0, 32'h000, 32'h0, 32'h0,       2, 0, 1, 1, 0, 9'h000, 9'h000, 2'b10, 0, 1, 32'hA6020391, 1, 32'h0000BBCC});

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_trap", {31'b0, trap_align}, 32'h0);
    chk("rst_valid", {31'b0, rdata_valid}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rdata_hi", rdata_hi, 32'h0);
    chk("rst_ram_ctl", {28'b0, ram_en, ram_rw, ram_sign, |ram_size}, 32'h0);
    chk("rst_ram_addr", {23'b0, ram_addr}, 32'h0);
    chk("rst_ram_din", ram_din, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i]);
      chk({vecs[i].name, " stall_cycles"}, n_stall, vecs[i].e_stall);
      chk({vecs[i].name, " trap_pulses"}, n_trap, vecs[i].e_trap);
      chk({vecs[i].name, " valid_pulses"}, n_valid, vecs[i].e_valid);
      chk({vecs[i].name, " en_cycles"}, n_en, vecs[i].e_en);
      chk({vecs[i].name, " write_cycles"}, n_wr, vecs[i].e_wr);
      chk({vecs[i].name, " stray_rw"}, n_stray, 0);
      if (vecs[i].e_en > 0) begin
        chk({vecs[i].name, " addr0"}, {23'b0, g_a0}, {23'b0, vecs[i].e_a0});
        chk({vecs[i].name, " size0"}, {30'b0, g_sz0}, {30'b0, vecs[i].e_sz0});
        chk({vecs[i].name, " sign"}, {31'b0, g_sign}, {31'b0, vecs[i].e_sign});
      end
      if (vecs[i].e_en > 1) chk({vecs[i].name, " addr1"}, {23'b0, g_a1}, {23'b0, vecs[i].e_a1});
      if (vecs[i].chk_rd) chk({vecs[i].name, " rdata"}, rdata, vecs[i].e_rdata);
      if (vecs[i].chk_hi) chk({vecs[i].name, " rdata_hi"}, rdata_hi, vecs[i].e_rdata_hi);
    end
    chk("std8 mem_lo", mem_word(9'h008), 32'hAEEABBA6);
    chk("std8 mem_hi", mem_word(9'h00C), 32'h0000BBCC);

    // STD interrupted by reset during its second word.
    req_valid = 1'b1; req_load = 1'b0; req_size = 2'b11; req_signed = 1'b0;
    req_addr = 32'h010; req_wdata = 32'h11111111; req_wdata_hi = 32'h22222222;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_hi en_before", {30'b0, ram_en, ram_rw}, 32'h3);
    chk("rst_hi addr_before", {23'b0, ram_addr}, 32'h014);
    #2;
    rst_n = 1'b0; req_valid = 1'b0;
    #1;
    chk("rst_hi en_after", {30'b0, ram_en, ram_rw}, 32'h0);
    chk("rst_hi stall_after", {31'b0, stall}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi mem_lo", mem_word(9'h010), 32'h11111111);
    chk("rst_hi mem_hi", mem_word(9'h014), 32'h00000000);
    chk("rst_hi rdata", rdata, 32'h0);
    chk("rst_hi rdata_hi", rdata_hi, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

- Memory-stage access controller that sits directly upstream of `ram_512x8`, the data RAM. It takes one load/store request per instruction from the pipeline MEM stage and checks alignment.
- It drives the RAM's Enable/ReadWrite/SignExtend/Size/Address/DataIn signals from registers, so every access is held stable for one full cycle.
- LDD/STD are split into two sequential word accesses, even register first at the lower address (big-endian). The pipeline is stalled until the result is ready.

## Interface
Parameters:
- `ADDR_W`, 9: RAM address width; `req_addr` bits above `ADDR_W-1` are ignored (wrap).

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `rst_n`  in  1  reset; one clock, reset is asynchronous and active-low
- `req_valid`  in  1  MEM stage holds a memory op; held stable while `stall`=1
- `req_load`  in  1  1 = load, 0 = store
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 doubleword
- `req_signed`  in  1  sign-extend byte/half loads
- `req_addr`  in  32  effective address
- `req_wdata`  in  32  store data (even register for STD)
- `req_wdata_hi`  in  32  odd register for STD
- `stall`  out  1  hold pipeline (combinational)
- `trap_align`  out  1  misalignment trap, one-cycle pulse
- `rdata`  out  32  load result (even register for LDD)
- `rdata_hi`  out  32  odd register for LDD
- `rdata_valid`  out  1  load result valid, one-cycle pulse
- `ram_en`, `ram_rw`, `ram_sign`  out  1 each  RAM Enable, ReadWrite (1 = write), SignExtend
- `ram_size`  out  2  RAM Size
- `ram_addr`  out  `ADDR_W`  RAM Address
- `ram_din`  out  32  RAM DataIn
- `ram_dout`  in  32  RAM DataOut (combinational, already sized/extended)

## Operation
- States:
  - IDLE: no RAM access.
  - ACC_LO: first (or only) RAM access.
  - ACC_HI: second word of LDD/STD.
  - RESP: result ready; pipeline released.
  - TRAP: misalignment reported; pipeline released.
- Alignment check in IDLE:
  - half needs `addr[0]`=0
  - word needs `addr[1:0]`=0
  - dword needs `addr[2:0]`=0
- Transitions:
  - IDLE & req_valid & misaligned -> TRAP.
  - IDLE & req_valid & aligned -> ACC_LO.
  - ACC_LO -> ACC_HI if size=11, else -> RESP.
  - ACC_HI -> RESP.
  - RESP -> IDLE; TRAP -> IDLE. `req_valid` is not sampled in RESP/TRAP.
- `stall` = (IDLE & req_valid) | ACC_LO | ACC_HI.
- RAM outputs in ACC_LO (loaded on the edge entering it):
  - `ram_en`=1, `ram_rw`=!req_load
  - `ram_size` = req_size, or 10 for doubleword
  - `ram_addr` = req_addr[ADDR_W-1:0], `ram_din` = req_wdata
  - `ram_sign` = req_load & req_signed & (size is 00 or 01), else 0
- RAM outputs in ACC_HI: `ram_addr` = ACC_LO address + 4, `ram_din` = req_wdata_hi, size 10, `ram_sign` = 0.
- In all other states `ram_en`=0 and `ram_rw`=0, so no stray writes. `ram_addr`/`ram_din` hold their last value.
- Load data capture:
  - `rdata` <= `ram_dout` on the edge leaving ACC_LO.
  - `rdata_hi` <= `ram_dout` on the edge leaving ACC_HI.
  - Both hold until overwritten; `rdata_hi` is untouched by non-dword loads.
- `rdata_valid`=1 in RESP for loads only; `trap_align`=1 in TRAP only.
- An aligned dword never crosses the 512-byte boundary; the +4 never wraps.

## Timing
- Reset: state IDLE. `stall`=0 (if req_valid=0), `trap_align`=0, `rdata_valid`=0. `rdata`, `rdata_hi`, `ram_*` outputs all 0. Asynchronous: RAM enable/write drop immediately on `rst_n` fall.
- Byte/half/word op: request in cycle T, ACC_LO in T+1, RESP in T+2. Stall is high in T and T+1; the pipeline advances at the end of T+2.
- Doubleword op: ACC_LO T+1, ACC_HI T+2, RESP T+3; stall is high 3 cycles.
- Misaligned op: TRAP in T+1; stall is high for T only; no RAM access occurs.
- A store's write occurs during the ACC cycle(s) while `ram_en`&`ram_rw`=1, exactly one cycle per word.
- Reset during ACC_HI of STD: the first word stays written; the second is never written.
- Back-to-back ops: the next request is seen in the IDLE cycle following RESP/TRAP. Minimum spacing is 3 cycles (4 for dword).

## Test plan
- RAM bytes 0x004..0x007 = 12 34 56 78; word load @0x004 -> stall high 2 cycles; RESP: `rdata`=0x12345678, `rdata_valid` pulse 1 cycle.
- Byte 0x91 @0x003 -> signed byte load gives `rdata`=0xFFFFFF91 with `ram_sign`=1; unsigned load gives 0x00000091.
- STD @0x008 with wdata 0xAEEABBA6 and wdata_hi 0x0000BBCC:
  - Expect two write cycles: addr 0x008 then 0x00C, size 10.
  - Then LDD @0x008 -> `rdata`=0xAEEABBA6, `rdata_hi`=0x0000BBCC; RESP in T+3.
- Half load @0x005 -> `trap_align` 1 cycle in T+1, `ram_en` never 1, stall high 1 cycle, `rdata` unchanged.
- STD @0x010 (0x11111111/0x22222222) over RAM preset to 0 at 0x010..0x017; `rst_n` low in ACC_HI:
  - `ram_en`/`ram_rw`/`stall` drop immediately.
  - Then word 0x010 = 0x11111111 and 0x014 = 0x00000000.
- Byte store 0xA6 @0x000, then word load @0x000 back-to-back -> `rdata`[31:24]=0xA6, other bytes preserved; `ram_rw`=0 in the cycles between the two ops.
